bmem_burst_responder: RTL and testbench

- Memory-side responder for the bmem burst interface driven by the cacheline adapters.
- Accepts single-cycle read requests and queues several at once, so stream-buffer prefetches can pipeline.
- Accepts 4-beat write bursts and returns 4-beat read bursts in request order after a programmable minimum latency.
- Backed by an internal 256-bit-line array; serves as the synthesizable memory model for adapter bring-up and verification.

---
 rtl/bmem_burst_responder.sv | 171 +++++++++++++++++
 tb/tb_bmem_burst_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_burst_responder.sv
// Memory-side responder for the bmem burst interface.
// Queues up to QUEUE_DEPTH line reads, each snapshotted from the line array when it is
// accepted, and returns them in order as 4-beat bursts after at least READ_LATENCY cycles.
// Write bursts assemble a full 256-bit line and commit it to the array on the last beat.
module bmem_burst_responder #(
    parameter int unsigned READ_LATENCY  = 8,
    parameter int unsigned QUEUE_DEPTH   = 4,
    parameter int unsigned LINE_IDX_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        protocol_error
);

    localparam int unsigned PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned DlyW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned Lines = 2 ** LINE_IDX_BITS;
    // The accept cycle counts as the first elapsed latency cycle, so the head reaches zero
    // READ_LATENCY cycles after acceptance and beat 0 follows one cycle later.
    localparam logic [DlyW-1:0] DlyInit = DlyW'(READ_LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StBurst} r_state_e;

    // Line array and read queue storage (not reset)
    logic [255:0]     mem    [Lines];
    logic [31:0]      q_addr [QUEUE_DEPTH];
    logic [255:0]     q_line [QUEUE_DEPTH];
    logic [DlyW-1:0]  q_dly  [QUEUE_DEPTH];

    logic [PtrW-1:0]  head_q, tail_q, head_nxt;
    logic [CntW-1:0]  count_q;

    r_state_e         r_state_q, r_state_d;
    logic [1:0]       beat_q, beat_d;
    logic             deq;

    logic             wr_active_q;
    logic [1:0]       wr_beat_q;
    logic [31:0]      wr_addr_q;
    logic [191:0]     wr_buf_q;

    logic             err_q, err_d;
    logic             rd_accept, wr_accept, head_due, next_due;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(QUEUE_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Handshake decode and protocol checking
    always_comb begin
        bmem_ready = !rst && ((count_q < CntW'(QUEUE_DEPTH)) || wr_active_q);
        rd_accept  = bmem_read && bmem_ready && !bmem_write && !wr_active_q;
        wr_accept  = bmem_write && bmem_ready;
        head_nxt   = ptr_inc(head_q);
        head_due   = (count_q != '0) && (q_dly[head_q] == '0);
        next_due   = (count_q > CntW'(1)) && (q_dly[head_nxt] == '0);
        err_d      = (bmem_ready && bmem_read && (bmem_write || wr_active_q))
                   || (bmem_write && wr_active_q && (bmem_addr != wr_addr_q));
    end

    // Read return FSM: next state, beat sequencing and dequeue
    always_comb begin
        r_state_d = r_state_q;
        beat_d    = beat_q;
        deq       = 1'b0;
        unique case (r_state_q)
            StIdle: begin
                if (head_due) begin
                    r_state_d = StBurst;
                    beat_d    = 2'd0;
                end
            end
            StBurst: begin
                if (beat_q == 2'd3) begin
                    deq    = 1'b1;
                    beat_d = 2'd0;
                    // Chain straight into the next due burst without a bubble
                    if (!next_due) begin
                        r_state_d = StIdle;
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                r_state_d = StIdle;
            end
        endcase
    end

    // Return data path: head entry sliced by the current beat
    always_comb begin
        bmem_rvalid    = (r_state_q == StBurst);
        bmem_raddr     = q_addr[head_q];
        bmem_rdata     = q_line[head_q][{beat_q, 6'd0} +: 64];
        protocol_error = err_q;
    end

    // Control state: FSM, queue pointers/count, write burst tracking, error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= StIdle;
            beat_q      <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wr_active_q <= 1'b0;
            wr_beat_q   <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            beat_q    <= beat_d;
            if (rd_accept) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (deq) begin
                head_q <= head_nxt;
            end
            count_q <= count_q + CntW'(rd_accept) - CntW'(deq);
            if (wr_accept) begin
                if (!wr_active_q) begin
                    wr_active_q <= 1'b1;
                    wr_beat_q   <= 2'd1;
                end else if (wr_beat_q == 2'd3) begin
                    wr_active_q <= 1'b0;
                    wr_beat_q   <= 2'd0;
                end else begin
                    wr_beat_q <= wr_beat_q + 2'd1;
                end
            end
            err_q <= err_d;
        end
    end

    // Data storage: queue entries, latency countdowns, write assembly and array commit.
    // Accepts are already blocked during reset through bmem_ready.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (rd_accept && (tail_q == PtrW'(i))) begin
                q_addr[i] <= bmem_addr;
                q_line[i] <= mem[bmem_addr[5 +: LINE_IDX_BITS]];
                q_dly[i]  <= DlyInit;
            end else if (q_dly[i] != '0) begin
                q_dly[i] <= q_dly[i] - 1'b1;
            end
        end
        if (wr_accept) begin
            if (!wr_active_q) begin
                wr_addr_q       <= bmem_addr;
                wr_buf_q[63:0]  <= bmem_wdata;
            end else if (wr_beat_q == 2'd3) begin
                mem[wr_addr_q[5 +: LINE_IDX_BITS]] <= {bmem_wdata, wr_buf_q};
            end else begin
                wr_buf_q[{wr_beat_q, 6'd0} +: 64] <= bmem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Directed bench for bmem_burst_responder with a beat scoreboard and a line model.
module tb_bmem_burst_responder;

    localparam int unsigned LB = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        protocol_error;

    bmem_burst_responder #(
        .READ_LATENCY  (8),
        .QUEUE_DEPTH   (4),
        .LINE_IDX_BITS (LB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bmem_addr      (bmem_addr),
        .bmem_read      (bmem_read),
        .bmem_write     (bmem_write),
        .bmem_wdata     (bmem_wdata),
        .bmem_ready     (bmem_ready),
        .bmem_raddr     (bmem_raddr),
        .bmem_rdata     (bmem_rdata),
        .bmem_rvalid    (bmem_rvalid),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } beat_t;

    beat_t        exp_q[$];
    int           rv_cyc[$];
    logic [255:0] model[int];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every returned beat must match the oldest expected beat
    always @(negedge clk) begin
        beat_t e;
        if (bmem_rvalid === 1'b1) begin
            rv_cyc.push_back(cyc);
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("raddr", 64'(bmem_raddr), 64'(e.a));
                check("rdata", bmem_rdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bmem_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check(tag, 64'(bmem_ready), 64'd1);
    endtask

    task automatic write_line(input logic [31:0] a, input logic [255:0] line);
        for (int b = 0; b < 4; b++) begin
            bmem_write = 1'b1;
            bmem_addr  = a;
            bmem_wdata = line[64*b +: 64];
            wait_ready("write_ready");
            tick();
        end
        bmem_write = 1'b0;
        model[int'(a[5 +: LB])] = line;
    endtask

    // Leaves bmem_read high so consecutive calls issue back-to-back requests
    task automatic read_req(input logic [31:0] a, output int acc);
        logic [255:0] line;
        bmem_read = 1'b1;
        bmem_addr = a;
        wait_ready("read_ready");
        acc  = cyc;
        line = model[int'(a[5 +: LB])];
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{a: a, d: line[64*b +: 64]});
        end
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bmem_rvalid === 1'b1) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic int at(input int i);
        return (i < rv_cyc.size()) ? rv_cyc[i] : -1;
    endfunction

    initial begin
        int acc[5];
        int a0;
        logic [255:0] l100;

        rst = 1'b1; bmem_read = 1'b0; bmem_write = 1'b0; bmem_addr = '0; bmem_wdata = '0;
        tick(); tick(); tick();
        check("rst_ready", 64'(bmem_ready), 64'd0);
        check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("rst_perr", 64'(protocol_error), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bmem_ready), 64'd1);

        // Write then read one line; check minimum latency and contiguous beats
        write_line(32'h40, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        rv_cyc.delete();
        read_req(32'h40, acc[0]);
        bmem_read = 1'b0;
        drain("t1_drain");
        check("t1_nbeats", 64'(rv_cyc.size()), 64'd4);
        check("t1_first", 64'(at(0)), 64'(acc[0] + 9));
        check("t1_last", 64'(at(3)), 64'(acc[0] + 12));

        // Four pipelined reads: sixteen beats with no bubble
        write_line(32'h00, {4{64'h0A0A_0000_0000_0001}} ^ 256'h1234);
        write_line(32'h20, {4{64'h0B0B_0000_0000_0002}} ^ 256'h5678 << 64);
        write_line(32'h60, {4{64'h0D0D_0000_0000_0004}} ^ 256'h9ABC << 128);
        rv_cyc.delete();
        for (int i = 0; i < 4; i++) read_req(32'(i * 32'h20), acc[i]);
        bmem_read = 1'b0;
        check("t2_accept_span", 64'(acc[3] - acc[0]), 64'd3);
        drain("t2_drain");
        check("t2_nbeats", 64'(rv_cyc.size()), 64'd16);
        check("t2_span", 64'(at(15) - at(0)), 64'd15);
        check("t2_first", 64'(at(0)), 64'(acc[0] + 9));

        // Five reads with a 4-deep queue: fifth waits for the first burst to finish
        rv_cyc.delete();
        for (int i = 0; i < 5; i++) read_req(32'((i % 4) * 32'h20), acc[i]);
        bmem_read = 1'b0;
        check("t3_fifth_accept", 64'(acc[4] - acc[0]), 64'd13);
        drain("t3_drain");
        check("t3_nbeats", 64'(rv_cyc.size()), 64'd20);

        // Read returns the snapshot taken at accept, not a later write
        write_line(32'h80, {4{64'h0123_4567_89AB_CDEF}});
        read_req(32'h80, a0);
        bmem_read = 1'b0;
        write_line(32'h80, {64'hFEED_0003, 64'hFEED_0002, 64'hFEED_0001, 64'hFEED_0000});
        drain("t4_old_drain");
        read_req(32'h80, a0);
        bmem_read = 1'b0;
        drain("t4_new_drain");

        // Protocol errors during a write burst to 0x100
        l100 = {64'hC0DE_0003, 64'hC0DE_0002, 64'hC0DE_0001, 64'hC0DE_0000};
        rv_cyc.delete();
        bmem_addr = 32'h100; bmem_read = 1'b1; bmem_write = 1'b1; bmem_wdata = l100[63:0];
        tick();
        check("t5_rw_err", 64'(protocol_error), 64'd1);
        bmem_read = 1'b0; bmem_wdata = l100[127:64];
        tick();
        check("t5_beat1_noerr", 64'(protocol_error), 64'd0);
        bmem_write = 1'b0; bmem_read = 1'b1;
        tick();
        check("t5_read_in_burst", 64'(protocol_error), 64'd1);
        bmem_read = 1'b0; bmem_write = 1'b1; bmem_wdata = l100[191:128];
        tick();
        check("t5_beat2_noerr", 64'(protocol_error), 64'd0);
        bmem_addr = 32'h120; bmem_wdata = l100[255:192];
        tick();
        check("t5_addr_err", 64'(protocol_error), 64'd1);
        bmem_write = 1'b0;
        model[int'(8)] = l100;
        repeat (20) tick();
        check("t5_no_read", 64'(rv_cyc.size()), 64'd0);
        read_req(32'h100, a0);
        bmem_read = 1'b0;
        drain("t5_drain");

        // Reset during beat 2 of a burst with two more reads queued
        for (int i = 0; i < 3; i++) read_req(32'(i * 32'h20), acc[i]);
        bmem_read = 1'b0;
        begin
            int n = 0;
            while (bmem_rvalid !== 1'b1 && n < 64) begin
                tick();
                n++;
            end
        end
        check("t6_rvalid_seen", 64'(bmem_rvalid), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_rvalid_off", 64'(bmem_rvalid), 64'd0);
        check("t6_ready_rst", 64'(bmem_ready), 64'd0);
        exp_q.delete();
        rv_cyc.delete();
        tick();
        rst = 1'b0;
        #1;
        check("t6_ready_after", 64'(bmem_ready), 64'd1);
        repeat (30) tick();
        check("t6_quiet", 64'(rv_cyc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
